// File: rtl/add.sv
// add: registered WIDTH-bit adder with carry-in, unsigned carry-out and signed overflow.
// The result stage uses a single-entry valid/ready handshake and sustains one result per cycle.
`default_nettype none

module add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH:0] sum;
  logic           sum_ovf;
  logic           accept;

  assign sum     = {1'b0, in0} + {1'b0, in1} + {{WIDTH{1'b0}}, cin};
  assign sum_ovf = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);

  // The output slot may be refilled on the same edge that the consumer drains it.
  assign in_ready = rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= sum[WIDTH-1:0];
      cout      <= sum[WIDTH];
      overflow  <= sum_ovf;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add.sv
// tb_add: randomized and directed checks of add against an arithmetic reference model.
`default_nettype none

module tb_add;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             cin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;

  add #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .cout(cout),
    .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: what the result register should hold.
  logic             m_valid;
  logic [WIDTH-1:0] m_out;
  logic             m_cout;
  logic             m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Full-width arithmetic: unsigned sum for carry, signed sum range for overflow.
  task automatic ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                         output logic [WIDTH-1:0] s, output logic co, output logic ov);
    longint u;
    longint sv;
    u  = longint'({32'd0, a}) + longint'({32'd0, b}) + longint'(c);
    sv = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    s  = u[WIDTH-1:0];
    co = (u >= 64'sh1_0000_0000);
    ov = (sv > 64'sh7FFF_FFFF) || (sv < -64'sh8000_0000);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check({tag, ".out"},      64'(out),      64'(m_out));
      check({tag, ".cout"},     64'(cout),     64'(m_cout));
      check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    end
  endtask

  // One clock cycle: drive after the falling edge, check ready before the rising edge,
  // advance the model at the edge, then check registered outputs just after it.
  task automatic cycle(input string tag, input logic iv, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic c, input logic ordy);
    logic exp_rdy;
    logic acc;
    logic [WIDTH-1:0] s;
    logic co, ov;
    @(negedge clk);
    in_valid  = iv;
    in0       = a;
    in1       = b;
    cin       = c;
    out_ready = ordy;
    #1;
    exp_rdy = !m_valid || ordy;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    acc = iv && exp_rdy;
    @(posedge clk);
    if (acc) begin
      ref_add(a, b, c, s, co, ov);
      m_valid = 1'b1;
      m_out   = s;
      m_cout  = co;
      m_ovf   = ov;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".out"},       64'(out),       64'd0);
    check({tag, ".cout"},      64'(cout),      64'd0);
    check({tag, ".overflow"},  64'(overflow),  64'd0);
    check({tag, ".in_ready"},  64'(in_ready),  64'd0);
  endtask

  // Drop reset between edges while a result is held, then release it.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_zero(tag);
    m_valid = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 check_reset_zero({tag, ".held"});
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    #1 check({tag, ".ready_after"}, 64'(in_ready), 64'd1);
    check({tag, ".valid_after"}, 64'(out_valid), 64'd0);
  endtask

  logic [WIDTH-1:0] ra, rb;

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b0; in0 = '0; in1 = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_valid = 1'b0; m_out = '0; m_cout = 1'b0; m_ovf = 1'b0;
    #3 check_reset_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("por.ready_after", 64'(in_ready), 64'd1);

    cycle("basic",  1'b1, 32'd3,          32'd4,          1'b0, 1'b1);
    check("basic.value", 64'(out), 64'd7);
    cycle("carry",  1'b1, 32'hFFFF_FFFF,  32'd0,          1'b1, 1'b1);
    check("carry.cout", 64'(cout), 64'd1);
    cycle("ovf_pos", 1'b1, 32'h7FFF_FFFF, 32'd1,          1'b0, 1'b1);
    check("ovf_pos.flag", 64'(overflow), 64'd1);
    cycle("ovf_neg", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    check("ovf_neg.flag", 64'(overflow), 64'd1);
    cycle("drain",  1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Backpressure: hold one result, a second beat must wait, then both move on one edge.
    cycle("bp.load", 1'b1, 32'd100, 32'd23, 1'b0, 1'b0);
    cycle("bp.hold1", 1'b1, 32'd5, 32'd6, 1'b1, 1'b0);
    cycle("bp.hold2", 1'b1, 32'd5, 32'd6, 1'b1, 1'b0);
    check("bp.held", 64'(out), 64'd123);
    cycle("bp.release", 1'b1, 32'd5, 32'd6, 1'b1, 1'b1);
    check("bp.new", 64'(out), 64'd12);
    cycle("bp.drain", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      cycle("stream", 1'b1, WIDTH'(k), WIDTH'(2 * k), 1'b0, 1'b1);
      check("stream.seq", 64'(out), 64'(3 * k));
    end
    cycle("stream.drain", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    cycle("rst.load", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    async_reset("rst_mid");

    for (int i = 0; i < 300; i++) begin
      ra = pick();
      rb = pick();
      cycle("rand", 1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom),
            1'($urandom_range(0, 3) != 0));
    end

    cycle("rst2.load", 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    async_reset("rst_end");
    cycle("post_rst", 1'b1, 32'd3, 32'd4, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
